aurora_hls_monitor_sampler: RTL and testbench

Downstream consumer of the Aurora monitor counters. Periodically snapshots the five free-running 32-bit monitor counters and computes per-interval deltas. Emits each sample as a fixed 6-beat AXI4-Stream record toward the HLS kernel or DMA path. Records that cannot be sent because the stream is still busy are dropped and counted, never silently lost.

---
 rtl/aurora_hls_pkg.sv | 29 ++
 rtl/aurora_hls_interval_timer.sv | 35 +++
 rtl/aurora_hls_monitor_sampler.sv | 125 ++++++++++++
 tb/tb_aurora_hls_monitor_sampler.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aurora_hls_pkg.sv
// Shared definitions for the Aurora HLS monitor sampler.
// Holds the record magic, the field count, beat-index constants for the
// record layout, the sampler state enum and the header-builder helper.
package aurora_hls_pkg;

    localparam logic [7:0]  REC_MAGIC   = 8'hA5;
    localparam int unsigned FIELD_COUNT = 5;
    localparam int unsigned BEAT_W      = 3;

    // Record layout: header first, then one beat per monitor counter delta.
    localparam logic [BEAT_W-1:0] BEAT_HDR         = 3'd0;
    localparam logic [BEAT_W-1:0] BEAT_CORE_STATUS = 3'd1;
    localparam logic [BEAT_W-1:0] BEAT_RX_OVF      = 3'd2;
    localparam logic [BEAT_W-1:0] BEAT_TX_OVF      = 3'd3;
    localparam logic [BEAT_W-1:0] BEAT_TX          = 3'd4;
    localparam logic [BEAT_W-1:0] BEAT_RX          = 3'd5;
    localparam logic [BEAT_W-1:0] BEAT_LAST        = BEAT_RX;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } sampler_state_e;

    // Header beat: magic, field count, 16-bit sequence number.
    function automatic logic [31:0] rec_header(input logic [15:0] seq);
        return {REC_MAGIC, 8'(FIELD_COUNT), seq};
    endfunction

endpackage

// File: rtl/aurora_hls_interval_timer.sv
// Sample-period timer for the monitor sampler.
// Ports: clk_i, rst_i (sync, active-high), enable_i, interval_i (0 = off),
//        tick_c_o (combinational, one cycle per elapsed interval).
module aurora_hls_interval_timer
    import aurora_hls_pkg::*;
#(
    parameter int unsigned INTERVAL_WIDTH = 32
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      enable_i,
    input  logic [INTERVAL_WIDTH-1:0] interval_i,
    output logic                      tick_c_o
);

    logic [INTERVAL_WIDTH-1:0] timer_q;
    logic                      eligible_c;

    assign eligible_c = enable_i && (interval_i != '0);

    // ">=" rather than "==" so a lowered interval ticks on the next cycle.
    assign tick_c_o = eligible_c && (timer_q >= (interval_i - INTERVAL_WIDTH'(1)));

    // Timer is held at zero whenever sampling is not eligible.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            timer_q <= '0;
        end else if (!eligible_c || tick_c_o) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_q + INTERVAL_WIDTH'(1);
        end
    end

endmodule

// File: rtl/aurora_hls_monitor_sampler.sv
// Periodic snapshot of the five Aurora monitor counters, emitted as a
// 6-beat AXI4-Stream record (header + five per-interval deltas).
// Ports: clk_i, rst_i (sync, active-high), enable_i, interval_i,
//        five monitor counter inputs, m_axis_* stream master,
//        dropped_count_o (records lost to a busy stream), seq_o (tick count).
module aurora_hls_monitor_sampler
    import aurora_hls_pkg::*;
#(
    parameter int unsigned COUNTER_WIDTH  = 32,
    parameter int unsigned INTERVAL_WIDTH = 32
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      enable_i,
    input  logic [INTERVAL_WIDTH-1:0] interval_i,
    input  logic [COUNTER_WIDTH-1:0]  core_status_not_ok_count_i,
    input  logic [COUNTER_WIDTH-1:0]  fifo_rx_overflow_count_i,
    input  logic [COUNTER_WIDTH-1:0]  fifo_tx_overflow_count_i,
    input  logic [COUNTER_WIDTH-1:0]  tx_count_i,
    input  logic [COUNTER_WIDTH-1:0]  rx_count_i,
    output logic [COUNTER_WIDTH-1:0]  m_axis_tdata_o,
    output logic                      m_axis_tvalid_o,
    output logic                      m_axis_tlast_o,
    input  logic                      m_axis_tready_i,
    output logic [31:0]               dropped_count_o,
    output logic [15:0]               seq_o
);

    logic                     tick_c;
    sampler_state_e           state_q;
    logic [BEAT_W-1:0]        beat_q;
    logic [COUNTER_WIDTH-1:0] cur_c   [FIELD_COUNT];
    logic [COUNTER_WIDTH-1:0] prev_q  [FIELD_COUNT];
    logic [COUNTER_WIDTH-1:0] delta_q [FIELD_COUNT];
    logic [COUNTER_WIDTH-1:0] tdata_q;
    logic                     tvalid_q;
    logic                     tlast_q;
    logic [31:0]              dropped_q;
    logic [15:0]              seq_q;
    logic [15:0]              seq_d;
    logic                     accept_c;
    logic                     last_accept_c;
    logic                     busy_c;

    aurora_hls_interval_timer #(
        .INTERVAL_WIDTH (INTERVAL_WIDTH)
    ) u_timer (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .enable_i   (enable_i),
        .interval_i (interval_i),
        .tick_c_o   (tick_c)
    );

    // Counters in record beat order.
    always_comb begin
        cur_c[0] = core_status_not_ok_count_i;
        cur_c[1] = fifo_rx_overflow_count_i;
        cur_c[2] = fifo_tx_overflow_count_i;
        cur_c[3] = tx_count_i;
        cur_c[4] = rx_count_i;
    end

    assign accept_c      = tvalid_q && m_axis_tready_i;
    assign last_accept_c = accept_c && (beat_q == BEAT_LAST);
    // A tick coinciding with the final beat handshake is not a drop.
    assign busy_c        = (state_q == ST_SEND) && !last_accept_c;
    assign seq_d         = seq_q + 16'd1;

    // Sampler FSM, record buffer and statistics.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            beat_q    <= BEAT_HDR;
            tdata_q   <= '0;
            tvalid_q  <= 1'b0;
            tlast_q   <= 1'b0;
            dropped_q <= '0;
            seq_q     <= '0;
            for (int i = 0; i < int'(FIELD_COUNT); i++) begin
                prev_q[i]  <= '0;
                delta_q[i] <= '0;
            end
        end else begin
            if (tick_c) begin
                seq_q <= seq_d;
            end

            // Dropped records leave prev untouched so the next deltas span the gap.
            if (tick_c && busy_c && (dropped_q != '1)) begin
                dropped_q <= dropped_q + 32'd1;
            end

            if (tick_c && !busy_c) begin
                for (int i = 0; i < int'(FIELD_COUNT); i++) begin
                    delta_q[i] <= cur_c[i] - prev_q[i];
                    prev_q[i]  <= cur_c[i];
                end
                tdata_q  <= COUNTER_WIDTH'(rec_header(seq_d));
                tvalid_q <= 1'b1;
                tlast_q  <= 1'b0;
                beat_q   <= BEAT_HDR;
                state_q  <= ST_SEND;
            end else if ((state_q == ST_SEND) && accept_c) begin
                if (beat_q == BEAT_LAST) begin
                    tvalid_q <= 1'b0;
                    tlast_q  <= 1'b0;
                    state_q  <= ST_IDLE;
                end else begin
                    // Beat n+1 carries delta n.
                    tdata_q <= delta_q[beat_q];
                    tlast_q <= (beat_q == (BEAT_LAST - 3'd1));
                    beat_q  <= beat_q + 3'd1;
                end
            end
        end
    end

    assign m_axis_tdata_o  = tdata_q;
    assign m_axis_tvalid_o = tvalid_q;
    assign m_axis_tlast_o  = tlast_q;
    assign dropped_count_o = dropped_q;
    assign seq_o           = seq_q;

endmodule

// File: tb/tb_aurora_hls_monitor_sampler.sv
// Bench for aurora_hls_monitor_sampler: expected record beats are queued as
// stimulus is planned and compared as the DUT hands them over.
module tb_aurora_hls_monitor_sampler;

    typedef struct {
        logic [31:0] data;
        logic        last;
        int          cyc;
    } beat_t;

    typedef struct packed {
        logic [4:0][31:0] prev;
        logic [4:0][31:0] cur;
        logic [4:0][31:0] exp;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             enable;
    logic [31:0]      interval;
    logic [4:0][31:0] cnt;
    logic [31:0]      tdata;
    logic             tvalid;
    logic             tlast;
    logic             tready;
    logic [31:0]      dropped;
    logic [15:0]      seq;

    int    n_vec    = 0;
    int    n_err    = 0;
    int    edge_cnt = 0;
    int    base     = 0;
    beat_t exp_q[$];

    logic        stall_q = 1'b0;
    logic [31:0] stall_data;
    logic        stall_last;

    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    aurora_hls_monitor_sampler #(
        .COUNTER_WIDTH  (32),
        .INTERVAL_WIDTH (32)
    ) dut (
        .clk_i                      (clk),
        .rst_i                      (rst),
        .enable_i                   (enable),
        .interval_i                 (interval),
        .core_status_not_ok_count_i (cnt[0]),
        .fifo_rx_overflow_count_i   (cnt[1]),
        .fifo_tx_overflow_count_i   (cnt[2]),
        .tx_count_i                 (cnt[3]),
        .rx_count_i                 (cnt[4]),
        .m_axis_tdata_o             (tdata),
        .m_axis_tvalid_o            (tvalid),
        .m_axis_tlast_o             (tlast),
        .m_axis_tready_i            (tready),
        .dropped_count_o            (dropped),
        .seq_o                      (seq)
    );

    // Stream monitor: stall stability and scoreboard compare on each handshake.
    always @(negedge clk) begin
        beat_t e;
        int    now;
        now = edge_cnt - base;
        if (stall_q) begin
            n_vec++;
            if (!tvalid || tdata !== stall_data || tlast !== stall_last) begin
                n_err++;
                $display("FAIL stall_hold @%0d: valid=%0b data=0x%08h last=%0b, want valid=1 data=0x%08h last=%0b",
                         now, tvalid, tdata, tlast, stall_data, stall_last);
            end
        end
        stall_q    = tvalid && !tready;
        stall_data = tdata;
        stall_last = tlast;
        if (tvalid && tready) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_beat @%0d: data=0x%08h last=%0b, want no beat", now, tdata, tlast);
            end else begin
                e = exp_q.pop_front();
                if (tdata !== e.data || tlast !== e.last || (e.cyc >= 0 && now != e.cyc)) begin
                    n_err++;
                    $display("FAIL beat @%0d: data=0x%08h last=%0b, want data=0x%08h last=%0b cyc=%0d",
                             now, tdata, tlast, e.data, e.last, e.cyc);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0d: got 0x%08h, want 0x%08h", name, edge_cnt - base, act, exp);
        end
    endtask

    // Queue nbeats of a record; contig gives each beat an exact acceptance cycle.
    task automatic push_rec(input int s, input logic [4:0][31:0] d, input int hdr_cyc,
                            input int nbeats, input bit contig);
        beat_t b;
        logic [31:0] hdr;
        hdr = 32'hA505_0000 | 32'(s & 16'hFFFF);
        for (int j = 0; j < nbeats; j++) begin
            b.data = (j == 0) ? hdr : d[j-1];
            b.last = (j == 5);
            b.cyc  = contig ? hdr_cyc + j : ((j == 0) ? hdr_cyc : -1);
            exp_q.push_back(b);
        end
    endtask

    task automatic go_to(input int t);
        while (edge_cnt - base < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset(input bit en, input logic [31:0] iv);
        @(posedge clk);
        #1;
        rst = 1'b1; enable = 1'b0; interval = '0; cnt = '0; tready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0; enable = en; interval = iv; base = edge_cnt;
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        repeat (8) @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t             vecs[3];
        logic [4:0][31:0] d;
        int               gaps;

        vecs[0].prev = {32'hFFFF_FFF0, 32'd4, 32'd3, 32'd2, 32'd1};
        vecs[0].cur  = {32'h0000_0010, 32'd10, 32'd3, 32'd5, 32'd1};
        vecs[0].exp  = {32'h0000_0020, 32'd6, 32'd0, 32'd3, 32'd0};
        vecs[1].prev = {32'd100, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'h8000_0000};
        vecs[1].cur  = {32'd100, 32'h0000_0000, 32'd1, 32'd0, 32'h7FFF_FFFF};
        vecs[1].exp  = {32'd0, 32'd1, 32'd1, 32'd0, 32'hFFFF_FFFF};
        vecs[2].prev = {32'd50, 32'd40, 32'd30, 32'd20, 32'd10};
        vecs[2].cur  = {32'd52, 32'd1040, 32'd31, 32'd20, 32'd15};
        vecs[2].exp  = {32'd2, 32'd1000, 32'd1, 32'd0, 32'd5};

        rst = 1'b1; enable = 1'b0; interval = '0; cnt = '0; tready = 1'b1;
        fork
            begin
                #200000;
                $display("FAIL timeout: bench did not finish");
                $fatal(1);
            end
        join_none

        // Reset state.
        do_reset(1'b0, 32'd0);
        chk("rst_tvalid", 32'(tvalid), 32'd0);
        chk("rst_tlast", 32'(tlast), 32'd0);
        chk("rst_tdata", tdata, 32'd0);
        chk("rst_dropped", dropped, 32'd0);
        chk("rst_seq", 32'(seq), 32'd0);

        // Basic periodic records, tx +3 per interval.
        do_reset(1'b1, 32'd100);
        d = '0; d[3] = 32'd3;
        push_rec(1, d, 100, 6, 1'b1);
        push_rec(2, d, 200, 6, 1'b1);
        go_to(50);  cnt[3] = 32'd3;
        go_to(150); cnt[3] = 32'd6;
        go_to(201); enable = 1'b0;
        wait_drain(50);
        chk("a_seq", 32'(seq), 32'd2);
        chk("a_dropped", dropped, 32'd0);

        // Delta table, including wraparound.
        for (int v = 0; v < 3; v++) begin
            do_reset(1'b1, 32'd8);
            cnt = vecs[v].prev;
            push_rec(1, vecs[v].prev, 8, 6, 1'b1);
            push_rec(2, vecs[v].exp, 16, 6, 1'b1);
            go_to(9);  cnt = vecs[v].cur;
            go_to(16); enable = 1'b0;
            wait_drain(50);
        end

        // Long stall: two drops, prev held across them.
        do_reset(1'b1, 32'd100);
        tready = 1'b0;
        go_to(50);  cnt[3] = 32'd3;
        go_to(150); cnt[3] = 32'd6;
        chk("c_hdr_stalled", tdata, 32'hA505_0001);
        go_to(250); cnt[3] = 32'd9;
        go_to(300);
        chk("c_dropped_mid", dropped, 32'd2);
        chk("c_seq_mid", 32'(seq), 32'd3);
        go_to(350);
        d = '0; d[3] = 32'd3;
        push_rec(1, d, 350, 6, 1'b1);
        d[3] = 32'd9;
        push_rec(4, d, 400, 6, 1'b1);
        tready = 1'b1; cnt[3] = 32'd12;
        go_to(401); enable = 1'b0;
        wait_drain(50);
        chk("c_seq", 32'(seq), 32'd4);
        chk("c_dropped", dropped, 32'd2);

        // interval = 6: back-to-back with no gaps.
        do_reset(1'b1, 32'd6);
        for (int k = 1; k <= 10; k++) begin
            d = '0;
            d[4] = (k == 1) ? 32'd5 : 32'd6;
            push_rec(k, d, 6 * k, 6, 1'b1);
        end
        gaps = 0;
        for (int c = 0; c <= 65; c++) begin
            go_to(c);
            cnt[4] = 32'(c);
            if (c == 60) enable = 1'b0;
            if (c >= 6 && !tvalid) gaps++;
        end
        chk("d_gaps", 32'(gaps), 32'd0);
        chk("d_dropped", dropped, 32'd0);
        chk("d_seq", 32'(seq), 32'd10);
        wait_drain(50);

        // Enable dropped mid-record, then re-enabled.
        do_reset(1'b1, 32'd20);
        cnt[0] = 32'd7;
        d = '0; d[0] = 32'd7;
        push_rec(1, d, 20, 6, 1'b1);
        go_to(22); enable = 1'b0;
        go_to(60);
        chk("e_seq_hold", 32'(seq), 32'd1);
        chk("e_idle", 32'(tvalid), 32'd0);
        d[0] = 32'd2;
        push_rec(2, d, 80, 6, 1'b1);
        cnt[0] = 32'd9; enable = 1'b1;
        go_to(81); enable = 1'b0;
        wait_drain(50);

        // interval = 3: every other tick dropped; last-beat tick reloads.
        do_reset(1'b1, 32'd3);
        for (int k = 0; k < 5; k++) push_rec(2 * k + 1, '0, 3 + 6 * k, 6, 1'b1);
        go_to(30); enable = 1'b0;
        wait_drain(50);
        chk("f_dropped", dropped, 32'd5);
        chk("f_seq", 32'(seq), 32'd10);

        // Reset at beat 3 aborts the record and clears statistics.
        @(posedge clk);
        #1;
        base = edge_cnt;
        cnt[0] = 32'd7; interval = 32'd10; enable = 1'b1;
        d = '0; d[0] = 32'd7;
        push_rec(11, d, 10, 4, 1'b1);
        go_to(13); rst = 1'b1;
        @(posedge clk);
        #1;
        chk("g_tvalid", 32'(tvalid), 32'd0);
        chk("g_tlast", 32'(tlast), 32'd0);
        chk("g_tdata", tdata, 32'd0);
        chk("g_seq", 32'(seq), 32'd0);
        chk("g_dropped", dropped, 32'd0);
        chk("g_aborted", 32'(exp_q.size()), 32'd0);
        do_reset(1'b1, 32'd10);
        push_rec(1, '0, 10, 6, 1'b1);
        go_to(11); enable = 1'b0;
        wait_drain(50);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
